// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel edge pipeline: pixel/coordinate widths,
// packer FSM encoding and the layout of one buffered packed-byte entry.
package sobel_pkg;

  localparam int PIX_W   = 8;
  localparam int COORD_W = 8;
  localparam int WORD_W  = 5;
  localparam int ENTRY_W = PIX_W + COORD_W + WORD_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PACK  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [PIX_W-1:0]   data;
    logic [COORD_W-1:0] row;
    logic [WORD_W-1:0]  word;
    logic               last;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; a push while full only lands
// when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop)
      rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: nothing is visible until the count says so.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/edge_bit_packer.sv
// Packs the Sobel edge-bit stream MSB-first into bytes tagged with row, word
// index and end-of-frame, buffered in a FIFO toward the consumer.
//
// state | meaning
// IDLE  | no partial byte in progress
// PACK  | collecting bits of a byte
// DRAIN | frame ended; input ignored until the last byte transfers
module edge_bit_packer
  import sobel_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] LAST_COL   = 8'd255
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       In_Valid,
  input  logic       In_Bit,
  input  logic [7:0] In_Row,
  input  logic [7:0] In_Column,
  input  logic       In_End,
  output logic [7:0] Out_Data,
  output logic [7:0] Out_Row,
  output logic [4:0] Out_Word,
  output logic       Out_Last,
  output logic       Out_Valid,
  input  logic       Out_Ready,
  output logic       Stall,
  output logic       Overflow
);

  logic [1:0]  state_q, state_d;
  logic [7:0]  sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;

  logic        accept, complete, pop, dropped;
  logic        fifo_full, fifo_empty;
  logic [7:0]  byte_nxt;
  fifo_entry_t wr_entry, rd_entry, head;

  assign accept   = In_Valid && (state_q != ST_DRAIN);
  assign byte_nxt = sr_q | ({In_Bit, 7'b0} >> cnt_q);
  assign complete = accept && ((cnt_q == 3'd7) || (In_Column == LAST_COL) || In_End);
  assign pop      = Out_Valid && Out_Ready;
  assign dropped  = complete && fifo_full && !pop;

  always_comb begin
    wr_entry.data = byte_nxt;
    wr_entry.row  = In_Row;
    wr_entry.word = In_Column[7:3];
    wr_entry.last = In_End;
  end

  sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .reset (Reset),
    .push  (complete),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Gate the head so stale storage never shows while the FIFO is empty.
  assign head      = fifo_empty ? '0 : rd_entry;
  assign Out_Valid = !fifo_empty;
  assign Out_Data  = head.data;
  assign Out_Row   = head.row;
  assign Out_Word  = head.word;
  assign Out_Last  = head.last;
  assign Stall     = fifo_full;
  assign Overflow  = ovf_q;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q | dropped;
    if (accept) begin
      if (complete) begin
        sr_d  = '0;
        cnt_d = '0;
      end else begin
        sr_d  = byte_nxt;
        cnt_d = cnt_q + 1'b1;
      end
    end
    case (state_q)
      ST_IDLE, ST_PACK: begin
        // A dropped end-of-frame byte leaves nothing to drain.
        if (complete)
          state_d = (In_End && !dropped) ? ST_DRAIN : ST_IDLE;
        else if (accept)
          state_d = ST_PACK;
      end
      ST_DRAIN: if (pop && head.last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_edge_bit_packer.sv
// Bench for edge_bit_packer: directed scenarios plus randomized traffic
// checked against a queue-based model of the packing and buffering rules.
module tb_edge_bit_packer;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] row;
    logic [4:0] word;
    logic       last;
  } ent_t;

  logic       Clk, Reset;
  logic       In_Valid, In_Bit, In_End, Out_Ready;
  logic [7:0] In_Row, In_Column;
  logic [7:0] Out_Data, Out_Row;
  logic [4:0] Out_Word;
  logic       Out_Last, Out_Valid, Stall, Overflow;

  int n_tests = 0;
  int n_fail  = 0;

  ent_t mq[$];
  int   bits[$];
  bit   mdrain, movf;

  edge_bit_packer #(.FIFO_DEPTH(8), .LAST_COL(8'd10)) dut (
    .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Bit(In_Bit),
    .In_Row(In_Row), .In_Column(In_Column), .In_End(In_End),
    .Out_Data(Out_Data), .Out_Row(Out_Row), .Out_Word(Out_Word),
    .Out_Last(Out_Last), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Stall(Stall), .Overflow(Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic model_reset();
    mq.delete();
    bits.delete();
    mdrain = 0;
    movf   = 0;
  endtask

  // Applies one cycle of inputs, advances the reference model, samples 1ns after the edge.
  task automatic drive(input logic v, input logic b, input logic [7:0] r, input logic [7:0] c,
                       input logic e, input logic rdy);
    bit   acc;
    int   sum;
    ent_t en;
    In_Valid = v; In_Bit = b; In_Row = r; In_Column = c; In_End = e; Out_Ready = rdy;
    acc = v && !mdrain;
    if (rdy && mq.size() > 0) begin
      if (mq[0].last) mdrain = 0;
      void'(mq.pop_front());
    end
    if (acc) begin
      bits.push_back(int'(b));
      if (bits.size() == 8 || c == 8'd10 || e) begin
        sum = 0;
        foreach (bits[i]) sum += bits[i] << (7 - i);
        en.data = 8'(sum);
        en.row  = r;
        en.word = c[7:3];
        en.last = e;
        if (mq.size() < 8) begin
          mq.push_back(en);
          if (e) mdrain = 1;
        end else begin
          movf = 1;
        end
        bits.delete();
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input logic v, input logic rdy);
    Reset = 1'b1; In_Valid = v; In_Bit = 1'b1; In_End = 1'b0; Out_Ready = rdy;
    @(posedge Clk);
    #1;
    Reset = 1'b0; In_Valid = 1'b0;
    model_reset();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [7:0] row,
                           input logic rdy_early, input logic rdy_last);
    logic [7:0] dv;
    dv = d;
    for (int i = 0; i < 8; i++)
      drive(1'b1, dv[7-i], row, 8'(i), 1'b0, (i == 7) ? rdy_last : rdy_early);
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    n_tests++;
    if ({Out_Valid, Stall, Overflow, Out_Last} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got valid/stall/ovf/last=%b expected 0000",
               {Out_Valid, Stall, Overflow, Out_Last});
    end
    n_tests++;
    if ({Out_Data, Out_Row, Out_Word} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_fields: got data=%h row=%h word=%h expected 0", Out_Data, Out_Row, Out_Word);
    end
  endtask

  task automatic test_basic_pack();
    logic [7:0] pat;
    pat = 8'b1011_0001;
    for (int i = 0; i < 7; i++) drive(1'b1, pat[7-i], 8'd3, 8'(i), 1'b0, 1'b1);
    n_tests++;
    if (Out_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early: got valid=%b expected 0", Out_Valid);
    end
    drive(1'b1, pat[0], 8'd3, 8'd7, 1'b0, 1'b1);
    n_tests++;
    if ({Out_Valid, Out_Data, Out_Row, Out_Word, Out_Last} !== {1'b1, 8'hB1, 8'd3, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_pack: got v=%b d=%h r=%0d w=%0d l=%b expected v=1 d=b1 r=3 w=0 l=0",
               Out_Valid, Out_Data, Out_Row, Out_Word, Out_Last);
    end
  endtask

  task automatic test_row_close();
    for (int i = 8; i <= 10; i++) drive(1'b1, 1'b1, 8'd5, 8'(i), 1'b0, 1'b1);
    n_tests++;
    if ({Out_Valid, Out_Data, Out_Word, Out_Last} !== {1'b1, 8'hE0, 5'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL row_close: got v=%b d=%h w=%0d l=%b expected v=1 d=e0 w=1 l=0",
               Out_Valid, Out_Data, Out_Word, Out_Last);
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic test_frame_end();
    drive(1'b1, 1'b1, 8'd7, 8'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'd7, 8'd1, 1'b1, 1'b0);
    n_tests++;
    if ({Out_Valid, Out_Data, Out_Last} !== {1'b1, 8'hC0, 1'b1}) begin
      n_fail++;
      $display("FAIL frame_end: got v=%b d=%h l=%b expected v=1 d=c0 l=1", Out_Valid, Out_Data, Out_Last);
    end
    for (int i = 2; i < 12; i++) drive(1'b1, 1'b1, 8'd7, 8'(i), (i == 10), 1'b0);
    n_tests++;
    if ({Out_Valid, Out_Data, Out_Last, Stall} !== {1'b1, 8'hC0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL drain_ignore: got v=%b d=%h l=%b stall=%b expected v=1 d=c0 l=1 stall=0",
               Out_Valid, Out_Data, Out_Last, Stall);
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    n_tests++;
    if (Out_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_pop: got valid=%b expected 0", Out_Valid);
    end
    send_byte(8'h55, 8'd8, 1'b1, 1'b1);
    n_tests++;
    if ({Out_Valid, Out_Data, Out_Last} !== {1'b1, 8'h55, 1'b0}) begin
      n_fail++;
      $display("FAIL after_drain: got v=%b d=%h l=%b expected v=1 d=55 l=0", Out_Valid, Out_Data, Out_Last);
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [7:0] bytes [9];
    do_reset(1'b0, 1'b0);
    foreach (bytes[i]) bytes[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) send_byte(bytes[i], 8'(i), 1'b0, 1'b0);
    n_tests++;
    if ({Stall, Overflow} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_full: got stall=%b ovf=%b expected stall=1 ovf=0", Stall, Overflow);
    end
    send_byte(bytes[8], 8'd8, 1'b0, 1'b0);
    n_tests++;
    if ({Stall, Overflow} !== 2'b11) begin
      n_fail++;
      $display("FAIL bp_overflow: got stall=%b ovf=%b expected stall=1 ovf=1", Stall, Overflow);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
      n_tests++;
      if ({Out_Valid, Out_Data, Out_Row} !== {1'b1, bytes[i], 8'(i)}) begin
        n_fail++;
        $display("FAIL bp_drain[%0d]: got v=%b d=%h r=%0d expected v=1 d=%h r=%0d",
                 i, Out_Valid, Out_Data, Out_Row, bytes[i], i);
      end
      drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    end
    n_tests++;
    if ({Out_Valid, Overflow} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_empty: got v=%b ovf=%b expected v=0 ovf=1", Out_Valid, Overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] bytes [9];
    do_reset(1'b0, 1'b0);
    foreach (bytes[i]) bytes[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) send_byte(bytes[i], 8'(i), 1'b0, 1'b0);
    send_byte(bytes[8], 8'd8, 1'b0, 1'b1);
    n_tests++;
    if ({Stall, Overflow, Out_Data} !== {1'b1, 1'b0, bytes[1]}) begin
      n_fail++;
      $display("FAIL full_push_pop: got stall=%b ovf=%b head=%h expected stall=1 ovf=0 head=%h",
               Stall, Overflow, Out_Data, bytes[1]);
    end
    for (int i = 1; i < 9; i++) begin
      n_tests++;
      if ({Out_Valid, Out_Data, Out_Row} !== {1'b1, bytes[i], 8'(i)}) begin
        n_fail++;
        $display("FAIL fpp_drain[%0d]: got v=%b d=%h r=%0d expected v=1 d=%h r=%0d",
                 i, Out_Valid, Out_Data, Out_Row, bytes[i], i);
      end
      drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0, 1'b0);
    send_byte(8'hA5, 8'd1, 1'b0, 1'b0);
    send_byte(8'h3C, 8'd2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 8'd3, 8'(i), 1'b0, 1'b0);
    do_reset(1'b1, 1'b1);
    n_tests++;
    if ({Out_Valid, Stall, Overflow} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b stall=%b ovf=%b expected 000", Out_Valid, Stall, Overflow);
    end
    send_byte(8'h81, 8'd4, 1'b1, 1'b1);
    n_tests++;
    if ({Out_Valid, Out_Data, Out_Row} !== {1'b1, 8'h81, 8'd4}) begin
      n_fail++;
      $display("FAIL reset_repack: got v=%b d=%h r=%0d expected v=1 d=81 r=4", Out_Valid, Out_Data, Out_Row);
    end
  endtask

  task automatic test_random();
    ent_t exp_head;
    bit   exp_v;
    int   rdy_pct;
    do_reset(1'b0, 1'b0);
    rdy_pct = 50;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) rdy_pct = int'($urandom_range(5, 95));
      drive(($urandom_range(0, 9) < 7), 1'($urandom), 8'($urandom),
            8'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0),
            (int'($urandom_range(0, 99)) < rdy_pct));
      exp_v    = (mq.size() > 0);
      exp_head = exp_v ? mq[0] : '0;
      n_tests++;
      if (Out_Valid !== exp_v || Stall !== (mq.size() == 8) || Overflow !== movf ||
          {Out_Data, Out_Row, Out_Word, Out_Last} !== exp_head) begin
        n_fail++;
        $display("FAIL random cyc %0d: got v=%b stall=%b ovf=%b head=%h expected v=%b stall=%b ovf=%b head=%h",
                 cyc, Out_Valid, Stall, Overflow, {Out_Data, Out_Row, Out_Word, Out_Last},
                 exp_v, (mq.size() == 8), movf, exp_head);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; In_Valid = 1'b0; In_Bit = 1'b0; In_Row = '0; In_Column = '0;
    In_End = 1'b0; Out_Ready = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    test_reset();
    test_basic_pack();
    test_row_close();
    test_frame_end();
    test_backpressure();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
